// File: rtl/soc_system_pcp_0_cpu_0_oci_trace_capture.sv
// Trace capture for the PCP Nios II OCI debug path.
//
// Takes packed multi-slot trace buffers, serialises the valid slots one per
// cycle into an on-chip FIFO and presents them as a valid/ready stream.
// test_ending_i requests a graceful drain; test_has_ended_i aborts and
// flushes. Buffers that cannot be accepted are counted, not silently lost.
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   dct_buffer_i        packed slots, slot 0 in the LSBs
//   dct_count_i         number of valid slots starting at slot 0
//   dct_valid_i         buffer strobe; dct_ready_o says it can be taken
//   test_ending_i       graceful drain request
//   test_has_ended_i    abort and flush
//   tr_data_o/valid_o   FIFO head stream; tr_ready_i pops the head
//   fifo_level_o        FIFO occupancy
//   drop_count_o        saturating count of lost buffers
//   done_o              capture finished, sticky until reset
module soc_system_pcp_0_cpu_0_oci_trace_capture #(
  parameter int unsigned SLOT_W    = 15,
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [SLOT_W*NUM_SLOTS-1:0] dct_buffer_i,
  input  logic [CNT_W-1:0]            dct_count_i,
  input  logic                        dct_valid_i,
  output logic                        dct_ready_o,
  input  logic                        test_ending_i,
  input  logic                        test_has_ended_i,
  output logic [SLOT_W-1:0]           tr_data_o,
  output logic                        tr_valid_o,
  input  logic                        tr_ready_i,
  output logic [$clog2(DEPTH):0]      fifo_level_o,
  output logic [15:0]                 drop_count_o,
  output logic                        done_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned RemW = $clog2(NUM_SLOTS + 1);
  localparam int unsigned BufW = SLOT_W * NUM_SLOTS;

  typedef enum logic [1:0] {StIdle, StShift, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [BufW-1:0]     sr_q, sr_d;
  logic [RemW-1:0]     rem_q, rem_d;
  logic                ending_q, ending_d;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [LvlW-1:0]     level_q, level_d;
  logic [15:0]         drop_q;
  logic [SLOT_W-1:0]   mem_q [DEPTH];

  logic        push, pop, flush, drop_ev, full;
  int unsigned eff_cnt;

  // Full is judged on the registered level, so a same-cycle pop never frees
  // room for a push.
  assign full = (level_q == LvlW'(DEPTH));
  assign pop  = (level_q != '0) && tr_ready_i && !flush;

  always_comb begin
    eff_cnt = (32'(dct_count_i) > NUM_SLOTS) ? NUM_SLOTS : 32'(dct_count_i);
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    rem_d       = rem_q;
    ending_d    = ending_q;
    push        = 1'b0;
    flush       = 1'b0;
    drop_ev     = 1'b0;
    dct_ready_o = (state_q == StIdle);

    case (state_q)
      StIdle: begin
        if (test_ending_i) begin
          state_d = StDrain;
          // A buffer offered alongside the end request is lost.
          drop_ev = dct_valid_i;
        end else if (dct_valid_i && eff_cnt != 0) begin
          sr_d    = dct_buffer_i;
          rem_d   = RemW'(eff_cnt);
          state_d = StShift;
        end
      end
      StShift: begin
        if (test_ending_i) ending_d = 1'b1;
        if (!full) begin
          push  = 1'b1;
          sr_d  = sr_q >> SLOT_W;
          rem_d = rem_q - 1'b1;
          if (rem_q == RemW'(1)) begin
            state_d = (ending_q || test_ending_i) ? StDrain : StIdle;
          end
        end
      end
      StDrain: begin
        if (level_q == '0) state_d = StDone;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    if (dct_valid_i && !dct_ready_o) drop_ev = 1'b1;

    // Abort wins over everything; unpushed slots are discarded, not dropped.
    if (test_has_ended_i) begin
      state_d = StDone;
      flush   = 1'b1;
      push    = 1'b0;
      sr_d    = '0;
      rem_d   = '0;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      rem_q    <= '0;
      ending_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      rem_q    <= rem_d;
      ending_q <= ending_d;
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        level_q <= level_d;
      end
      if (drop_ev && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= sr_q[SLOT_W-1:0];
  end

  // Gate the head with valid so nothing stale is visible after reset/flush.
  assign tr_valid_o   = (level_q != '0);
  assign tr_data_o    = tr_valid_o ? mem_q[rptr_q] : '0;
  assign fifo_level_o = level_q;
  assign drop_count_o = drop_q;
  assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_soc_system_pcp_0_cpu_0_oci_trace_capture.sv
module tb_soc_system_pcp_0_cpu_0_oci_trace_capture;

  localparam int unsigned SLOT_W    = 15;
  localparam int unsigned NUM_SLOTS = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DEPTH     = 16;

  logic                        clk_i = 1'b0;
  logic                        reset_i;
  logic [SLOT_W*NUM_SLOTS-1:0] dct_buffer_i;
  logic [CNT_W-1:0]            dct_count_i;
  logic                        dct_valid_i;
  logic                        dct_ready_o;
  logic                        test_ending_i;
  logic                        test_has_ended_i;
  logic [SLOT_W-1:0]           tr_data_o;
  logic                        tr_valid_o;
  logic                        tr_ready_i;
  logic [$clog2(DEPTH):0]      fifo_level_o;
  logic [15:0]                 drop_count_o;
  logic                        done_o;

  int checks = 0;
  int errors = 0;
  int exp_k;

  soc_system_pcp_0_cpu_0_oci_trace_capture #(
    .SLOT_W    (SLOT_W),
    .NUM_SLOTS (NUM_SLOTS),
    .CNT_W     (CNT_W),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .dct_buffer_i     (dct_buffer_i),
    .dct_count_i      (dct_count_i),
    .dct_valid_i      (dct_valid_i),
    .dct_ready_o      (dct_ready_o),
    .test_ending_i    (test_ending_i),
    .test_has_ended_i (test_has_ended_i),
    .tr_data_o        (tr_data_o),
    .tr_valid_o       (tr_valid_o),
    .tr_ready_i       (tr_ready_i),
    .fifo_level_o     (fifo_level_o),
    .drop_count_o     (drop_count_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Send one buffer and wait until the block is idle again (no backpressure).
  task automatic send(input logic [14:0] s1, input logic [14:0] s0, input int cnt);
    dct_buffer_i = {s1, s0};
    dct_count_i  = CNT_W'(cnt);
    dct_valid_i  = 1'b1;
    cycle();
    dct_valid_i  = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    cycle();
  endtask

  // Cycle with in-order scoreboard check of every pop.
  task automatic tick();
    if (tr_valid_o && tr_ready_i) begin
      check("wrap_data", 32'(tr_data_o), 32'(15'h200 + 15'(exp_k)));
      exp_k++;
    end
    cycle();
  endtask

  initial begin
    reset_i          = 1'b1;
    dct_buffer_i     = '0;
    dct_count_i      = '0;
    dct_valid_i      = 1'b0;
    test_ending_i    = 1'b0;
    test_has_ended_i = 1'b0;
    tr_ready_i       = 1'b0;
    #12;
    check("rst_ready", 32'(dct_ready_o), 32'd1);
    check("rst_valid", 32'(tr_valid_o), 32'd0);
    check("rst_data",  32'(tr_data_o), 32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_drop",  32'(drop_count_o), 32'd0);
    check("rst_done",  32'(done_o), 32'd0);
    reset_i = 1'b0;
    cycle();

    // Single buffer, streaming consumer.
    tr_ready_i   = 1'b1;
    dct_buffer_i = {15'h1234, 15'h0ABC};
    dct_count_i  = 4'd2;
    dct_valid_i  = 1'b1;
    cycle();
    dct_valid_i = 1'b0;
    check("c1_ready", 32'(dct_ready_o), 32'd0);
    check("c1_valid", 32'(tr_valid_o), 32'd0);
    cycle();
    check("c2_ready", 32'(dct_ready_o), 32'd0);
    check("c2_valid", 32'(tr_valid_o), 32'd1);
    check("c2_data",  32'(tr_data_o), 32'h0ABC);
    cycle();
    check("c3_ready", 32'(dct_ready_o), 32'd1);
    check("c3_data",  32'(tr_data_o), 32'h1234);
    cycle();
    check("c4_valid", 32'(tr_valid_o), 32'd0);
    check("c4_level", 32'(fifo_level_o), 32'd0);

    // Count clamp and count zero.
    tr_ready_i = 1'b0;
    send(15'h0111, 15'h0222, 4);
    check("clamp_level", 32'(fifo_level_o), 32'd2);
    check("clamp_ready", 32'(dct_ready_o), 32'd1);
    send(15'h0333, 15'h0444, 0);
    check("zero_level", 32'(fifo_level_o), 32'd2);
    check("zero_drop",  32'(drop_count_o), 32'd0);
    tr_ready_i = 1'b1;
    check("clamp_d0", 32'(tr_data_o), 32'h0222);
    cycle();
    check("clamp_d1", 32'(tr_data_o), 32'h0111);
    cycle();
    check("clamp_empty", 32'(fifo_level_o), 32'd0);
    tr_ready_i = 1'b0;

    // Backpressure: 8 buffers fill the FIFO, the 9th stalls in shift.
    for (int b = 0; b < 8; b++) send(15'(16'h101 + 2 * b), 15'(16'h100 + 2 * b), 2);
    check("full_level", 32'(fifo_level_o), 32'd16);
    dct_buffer_i = {15'h111, 15'h110};
    dct_count_i  = 4'd2;
    dct_valid_i  = 1'b1;
    cycle();
    dct_valid_i = 1'b0;
    cycle();
    cycle();
    check("stall_ready", 32'(dct_ready_o), 32'd0);
    check("stall_level", 32'(fifo_level_o), 32'd16);
    check("stall_drop0", 32'(drop_count_o), 32'd0);
    dct_valid_i = 1'b1;
    cycle();
    dct_valid_i = 1'b0;
    check("stall_drop1", 32'(drop_count_o), 32'd1);
    tr_ready_i = 1'b1;
    for (int k = 0; k < 18; k++) begin
      check("bp_valid", 32'(tr_valid_o), 32'd1);
      check("bp_data", 32'(tr_data_o), 32'(16'h100 + k));
      cycle();
    end
    check("bp_empty", 32'(fifo_level_o), 32'd0);
    check("bp_ready", 32'(dct_ready_o), 32'd1);
    tr_ready_i = 1'b0;

    // Graceful end with 3 slots queued.
    send(15'h0B02, 15'h0A01, 2);
    send(15'h7FFF, 15'h0C03, 1);
    check("end_level", 32'(fifo_level_o), 32'd3);
    test_ending_i = 1'b1;
    cycle();
    test_ending_i = 1'b0;
    dct_valid_i   = 1'b1;
    cycle();
    dct_valid_i = 1'b0;
    check("end_drop",  32'(drop_count_o), 32'd2);
    check("end_ready", 32'(dct_ready_o), 32'd0);
    check("end_level3", 32'(fifo_level_o), 32'd3);
    tr_ready_i = 1'b1;
    check("end_d0", 32'(tr_data_o), 32'h0A01);
    cycle();
    check("end_d1", 32'(tr_data_o), 32'h0B02);
    cycle();
    check("end_d2", 32'(tr_data_o), 32'h0C03);
    cycle();
    check("end_done0", 32'(done_o), 32'd0);
    cycle();
    check("end_done1", 32'(done_o), 32'd1);
    check("end_ready_done", 32'(dct_ready_o), 32'd0);
    tr_ready_i = 1'b0;
    do_reset();
    check("post_rst_done", 32'(done_o), 32'd0);

    // Abort with 5 slots queued.
    send(15'h0002, 15'h0001, 2);
    send(15'h0004, 15'h0003, 2);
    send(15'h0000, 15'h0005, 1);
    check("abort_pre", 32'(fifo_level_o), 32'd5);
    test_has_ended_i = 1'b1;
    cycle();
    test_has_ended_i = 1'b0;
    check("abort_level", 32'(fifo_level_o), 32'd0);
    check("abort_valid", 32'(tr_valid_o), 32'd0);
    check("abort_done",  32'(done_o), 32'd1);
    do_reset();

    // Asynchronous reset in the middle of a shift.
    dct_buffer_i = {15'h0666, 15'h0555};
    dct_count_i  = 4'd2;
    dct_valid_i  = 1'b1;
    cycle();
    cycle();
    dct_valid_i = 1'b0;
    check("mid_drop",  32'(drop_count_o), 32'd1);
    check("mid_level", 32'(fifo_level_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("arst_ready", 32'(dct_ready_o), 32'd1);
    check("arst_valid", 32'(tr_valid_o), 32'd0);
    check("arst_data",  32'(tr_data_o), 32'd0);
    check("arst_level", 32'(fifo_level_o), 32'd0);
    check("arst_drop",  32'(drop_count_o), 32'd0);
    check("arst_done",  32'(done_o), 32'd0);
    cycle();
    reset_i = 1'b0;
    cycle();

    // Pointer wrap: 40 slots through a 16-deep FIFO in order.
    exp_k      = 0;
    tr_ready_i = 1'b1;
    for (int b = 0; b < 20; b++) begin
      dct_buffer_i = {15'(16'h201 + 2 * b), 15'(16'h200 + 2 * b)};
      dct_count_i  = 4'd2;
      dct_valid_i  = 1'b1;
      tick();
      dct_valid_i  = 1'b0;
      tick();
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check("wrap_count", 32'(exp_k), 32'd40);
    check("wrap_empty", 32'(fifo_level_o), 32'd0);
    check("wrap_drop",  32'(drop_count_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
